stm_focus_sequencer: RTL and testbench

- Controller that drives the focus-STM datapath. It issues one START/IDX request per sample tick and tracks completion by counting DOUT_VALID beats.
- Advances the focus index with wrap-around, and swaps between two STM segments only at cycle boundaries.
- Flags sample ticks that arrive while the datapath is still busy (overrun).
- Sits between the STM timing generator (UPDATE tick) and the focus-calculation datapath.

---
 rtl/stm_focus_sequencer.sv | 113 +++++++++++
 tb/tb_stm_focus_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stm_focus_sequencer.sv
// ============================================================================
// Module   : stm_focus_sequencer
// Purpose  : Issues one focus-calculation per STM sample tick, tracks beat
//            completion, advances the focus index and swaps segments at wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stm_focus_sequencer #(
    parameter int DEPTH     = 249,
    parameter int IDX_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic                 UPDATE,
    input  logic                 REQ_SEGMENT,
    input  logic [IDX_WIDTH-1:0] CYCLE_0,
    input  logic [IDX_WIDTH-1:0] CYCLE_1,
    input  logic                 DOUT_VALID,
    input  logic                 CLR_OVERRUN,
    output logic                 START,
    output logic [IDX_WIDTH-1:0] IDX,
    output logic                 SEGMENT,
    output logic                 BUSY,
    output logic                 OVERRUN,
    output logic                 DONE
);

    localparam int              C_CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [IDX_WIDTH-1:0] r_idx;
    logic                 r_seg;
    logic                 r_start;
    logic                 r_ovr;

    logic                 w_last;
    logic                 w_ovr_set;
    logic [IDX_WIDTH-1:0] w_cycle;

    // Completion must be visible on the very beat that finishes the run.
    assign w_last    = (r_state == S_RUN) && DOUT_VALID && (r_cnt == C_LAST);
    assign w_ovr_set = UPDATE && (r_state == S_RUN);
    assign w_cycle   = r_seg ? CYCLE_1 : CYCLE_0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_seg   <= 1'b0;
            r_start <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_start <= 1'b0;

            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (CLR_OVERRUN) begin
                r_ovr <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!ENABLE) begin
                        r_idx <= '0;
                        r_seg <= REQ_SEGMENT;
                    end else if (UPDATE) begin
                        r_start <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (DOUT_VALID) begin
                        if (r_cnt == C_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            // >= also catches a cycle length that shrank below IDX
                            if (r_idx >= w_cycle) begin
                                r_idx <= '0;
                                r_seg <= REQ_SEGMENT;
                            end else begin
                                r_idx <= r_idx + IDX_WIDTH'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + C_CNT_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign START   = r_start;
    assign IDX     = r_idx;
    assign SEGMENT = r_seg;
    assign BUSY    = (r_state == S_RUN);
    assign OVERRUN = r_ovr;
    assign DONE    = w_last;

endmodule

`default_nettype wire

// File: tb/tb_stm_focus_sequencer.sv
// ============================================================================
// Module   : tb_stm_focus_sequencer
// Purpose  : Self-checking bench for stm_focus_sequencer against a
//            transaction-level index/segment/overrun model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stm_focus_sequencer;

    localparam int DEPTH = 249;
    localparam int IW    = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ENABLE;
    logic          UPDATE;
    logic          REQ_SEGMENT;
    logic [IW-1:0] CYCLE_0;
    logic [IW-1:0] CYCLE_1;
    logic          DOUT_VALID;
    logic          CLR_OVERRUN;
    logic          START;
    logic [IW-1:0] IDX;
    logic          SEGMENT;
    logic          BUSY;
    logic          OVERRUN;
    logic          DONE;

    stm_focus_sequencer #(.DEPTH(DEPTH), .IDX_WIDTH(IW)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .UPDATE(UPDATE),
        .REQ_SEGMENT(REQ_SEGMENT), .CYCLE_0(CYCLE_0), .CYCLE_1(CYCLE_1),
        .DOUT_VALID(DOUT_VALID), .CLR_OVERRUN(CLR_OVERRUN),
        .START(START), .IDX(IDX), .SEGMENT(SEGMENT), .BUSY(BUSY),
        .OVERRUN(OVERRUN), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_chk   = 0;
    int n_err   = 0;
    int n_start = 0;
    int n_done  = 0;

    // Reference state: what the sequencer should hold between calculations
    int m_idx = 0;
    int m_seg = 0;
    int m_ovr = 0;

    always @(negedge CLK) begin
        if (START === 1'b1) n_start++;
        if (DONE === 1'b1)  n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Completion rule: wrap when the index has reached the active segment's last entry
    function automatic void model_advance();
        int c;
        c = (m_seg != 0) ? int'(CYCLE_1) : int'(CYCLE_0);
        if (m_idx >= c) begin
            m_idx = 0;
            m_seg = int'(REQ_SEGMENT);
        end else begin
            m_idx = m_idx + 1;
        end
    endfunction

    task automatic to_drive();
        @(posedge CLK);
        #1;
    endtask

    // gap: 0 = continuous, 1 = every other cycle, >=2 = random drop percentage
    task automatic run_calc(input int gap, input int ovr_cyc, input bit ovr_done,
                            input int clr_cyc, input string tag);
        int  s0, d0, beats, k, busy_bad;
        bit  dv, last;
        s0 = n_start;
        d0 = n_done;
        UPDATE = 1'b1;
        to_drive();
        UPDATE = 1'b0;
        @(negedge CLK);
        chk({tag, "_start"}, START, 1);
        chk({tag, "_start_idx"}, IDX, m_idx);
        chk({tag, "_start_seg"}, SEGMENT, m_seg);
        beats    = 0;
        busy_bad = 0;
        k        = 1;
        while (beats < DEPTH && k < 4000) begin
            to_drive();
            if (gap == 0)      dv = 1'b1;
            else if (gap == 1) dv = (k % 2) == 1;
            else               dv = ($urandom_range(0, 99) >= gap);
            last        = dv && (beats == DEPTH - 1);
            DOUT_VALID  = dv;
            UPDATE      = (k == ovr_cyc) || (last && ovr_done) || (k == clr_cyc);
            CLR_OVERRUN = (k == clr_cyc);
            @(negedge CLK);
            if (BUSY !== 1'b1) busy_bad++;
            if (UPDATE) m_ovr = 1;
            if (last) begin
                chk({tag, "_done_on_last"}, DONE, 1);
                if (gap == 1) chk({tag, "_done_cycle"}, k, 497);
            end
            if (dv) beats++;
            k++;
        end
        chk({tag, "_beats"}, beats, DEPTH);
        to_drive();
        DOUT_VALID  = 1'b0;
        UPDATE      = 1'b0;
        CLR_OVERRUN = 1'b0;
        model_advance();
        @(negedge CLK);
        chk({tag, "_busy_after"}, BUSY, 0);
        chk({tag, "_busy_during"}, busy_bad, 0);
        chk({tag, "_idx_after"}, IDX, m_idx);
        chk({tag, "_seg_after"}, SEGMENT, m_seg);
        chk({tag, "_ovr_after"}, OVERRUN, m_ovr);
        chk({tag, "_n_done"}, n_done - d0, 1);
        chk({tag, "_n_start"}, n_start - s0, 1);
    endtask

    initial begin
        int s0, d0;
        RESET = 1'b1; ENABLE = 1'b0; UPDATE = 1'b0; REQ_SEGMENT = 1'b0;
        CYCLE_0 = 16'd2; CYCLE_1 = 16'd0; DOUT_VALID = 1'b0; CLR_OVERRUN = 1'b0;
        repeat (2) to_drive();
        RESET  = 1'b0;
        ENABLE = 1'b1;
        @(negedge CLK);
        chk("rst_start", START, 0);
        chk("rst_idx", IDX, 0);
        chk("rst_seg", SEGMENT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ovr", OVERRUN, 0);
        chk("rst_done", DONE, 0);

        // Three calculations over a three-entry segment
        for (int i = 0; i < 3; i++) run_calc(0, 0, 1'b0, 0, "basic");

        // Segment swap only on the wrap
        CYCLE_0 = 16'd3;
        CYCLE_1 = 16'd1;
        run_calc(0, 0, 1'b0, 0, "swap_pre");
        to_drive();
        REQ_SEGMENT = 1'b1;
        for (int i = 0; i < 6; i++) run_calc(0, 0, 1'b0, 0, "swap");
        REQ_SEGMENT = 1'b0;

        // Overrun: mid-run and DONE-cycle drops, then set-beats-clear
        run_calc(0, 5, 1'b1, 0, "ovr");
        run_calc(0, 0, 1'b0, 10, "ovr_setclr");
        to_drive();
        CLR_OVERRUN = 1'b1;
        m_ovr = 0;
        to_drive();
        CLR_OVERRUN = 1'b0;
        @(negedge CLK);
        chk("ovr_cleared", OVERRUN, m_ovr);

        run_calc(1, 0, 1'b0, 0, "gap");

        // Reset in the middle of a calculation, then stray beats
        s0 = n_start;
        d0 = n_done;
        UPDATE = 1'b1;
        to_drive();
        UPDATE = 1'b0;
        DOUT_VALID = 1'b1;
        repeat (100) to_drive();
        RESET = 1'b1;
        DOUT_VALID = 1'b0;
        @(negedge CLK);
        chk("mrst_busy", BUSY, 0);
        chk("mrst_idx", IDX, 0);
        chk("mrst_seg", SEGMENT, 0);
        chk("mrst_start", START, 0);
        to_drive();
        RESET = 1'b0;
        DOUT_VALID = 1'b1;
        repeat (149) to_drive();
        DOUT_VALID = 1'b0;
        @(negedge CLK);
        m_idx = 0; m_seg = 0; m_ovr = 0;
        chk("mrst_no_done", n_done - d0, 0);
        chk("mrst_one_start", n_start - s0, 1);
        chk("mrst_busy_after", BUSY, 0);
        chk("mrst_ovr", OVERRUN, 0);
        run_calc(0, 0, 1'b0, 0, "post_rst");

        // Disabled: ticks ignored, index forced to zero, segment follows request
        to_drive();
        s0 = n_start;
        ENABLE = 1'b0;
        for (int i = 0; i < 6; i++) begin
            UPDATE = (i % 2) == 0;
            to_drive();
        end
        UPDATE = 1'b0;
        @(negedge CLK);
        m_idx = 0;
        m_seg = int'(REQ_SEGMENT);
        chk("dis_no_start", n_start - s0, 0);
        chk("dis_ovr", OVERRUN, 0);
        chk("dis_idx", IDX, 0);
        chk("dis_seg", SEGMENT, m_seg);
        to_drive();
        ENABLE = 1'b1;

        // Cycle length shrinks below the current index
        CYCLE_0 = 16'd7;
        for (int i = 0; i < 5; i++) run_calc(0, 0, 1'b0, 0, "grow");
        chk("shrink_pre_idx", IDX, 5);
        CYCLE_0 = 16'd2;
        run_calc(0, 0, 1'b0, 0, "shrink");
        chk("shrink_wrap", IDX, 0);

        // Randomized segment lengths, requests and strobe gaps
        for (int i = 0; i < 5; i++) begin
            CYCLE_0     = 16'($urandom_range(0, 3));
            CYCLE_1     = 16'($urandom_range(0, 3));
            REQ_SEGMENT = 1'($urandom_range(0, 1));
            run_calc(int'($urandom_range(20, 60)), 0, 1'b0, 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
